// File: rtl/cpu_controller_irq.sv
// RCPU control FSM: instruction decode, source addressing modes, memory wait
// states, vectored interrupt entry with link save, and sticky halt.
module cpu_controller_irq #(
  parameter int NUM_REGS = 3,
  parameter bit MEM_WAIT = 1'b1,
  parameter bit IRQ_EN   = 1'b1,
  parameter int LINK_REG = NUM_REGS - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         opcode,
  input  logic                mem_ready,
  input  logic                irq,
  output logic [1:0]          memAddr,
  output logic                mem_req,
  output logic                enPC,
  output logic                saveOpcode,
  output logic                saveMem,
  output logic [3:0]          aluFunc,
  output logic [2:0]          aluA,
  output logic [2:0]          aluB,
  output logic [NUM_REGS-1:0] enReg,
  output logic                irq_ack,
  output logic                halted,
  output logic [4:0]          state_dbg
);

  typedef enum logic [4:0] {
    FETCH    = 5'b00000,
    ATYPE    = 5'b00001,
    ITYPE    = 5'b00010,
    JTYPE    = 5'b00011,
    IRQ1     = 5'b00100,
    IRQ2     = 5'b00101,
    RIMMED   = 5'b10000,
    RADDRESS = 5'b10001,
    RABS1    = 5'b10010,
    RABS2    = 5'b10011,
    RABSI1   = 5'b10100,
    RABSI2   = 5'b10101,
    HALT     = 5'b11111
  } state_t;

  state_t state, nxt, tstate;
  logic   irq_q, pend;
  logic   rdy, rise, take, stall;
  logic   pc, sop, smem, ack;
  logic [NUM_REGS-1:0] en;
  logic [2:0] s1, src_a;
  logic       unused;

  assign unused = opcode[2];
  assign rdy    = MEM_WAIT ? mem_ready : 1'b1;
  assign rise   = IRQ_EN & irq & ~irq_q;
  // an edge seen during the execute cycle itself is taken immediately
  assign take   = pend | rise;
  assign s1     = opcode[11:9];
  assign src_a  = s1[2] ? 3'd5 : {1'b0, s1[1:0]};

  function automatic logic [NUM_REGS-1:0] dec(input logic [1:0] idx, input logic ok);
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      r[i] = ok && (idx == 2'(i));
    return r;
  endfunction

  function automatic logic [NUM_REGS-1:0] link_onehot();
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      r[i] = (i == LINK_REG);
    return r;
  endfunction

  always_comb begin
    if (opcode[15:12] == 4'b0000)     tstate = ATYPE;
    else if (opcode[15:14] == 2'b01)  tstate = ITYPE;
    else if (opcode[15])              tstate = JTYPE;
    else                              tstate = HALT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= nxt;
      irq_q <= irq;
      if (state != HALT) begin
        if (rise)                     pend <= 1'b1;
        else if (state == IRQ2 && rdy) pend <= 1'b0;
      end
    end
  end

  always_comb begin
    nxt     = state;
    mem_req = 1'b0;
    memAddr = 2'd0;
    aluFunc = 4'd0;
    aluA    = 3'd0;
    aluB    = 3'd0;
    pc      = 1'b0;
    sop     = 1'b0;
    smem    = 1'b0;
    ack     = 1'b0;
    en      = '0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        aluA = 3'd4; aluB = 3'd6;
        pc = 1'b1; sop = 1'b1;
        if (rdy) begin
          if (tstate == JTYPE || tstate == HALT || !s1[2]) nxt = tstate;
          else begin
            case (s1[1:0])
              2'b00:   nxt = RIMMED;
              2'b01:   nxt = RABS1;
              2'b10:   nxt = RADDRESS;
              default: nxt = RABSI1;
            endcase
          end
        end
      end
      RIMMED, RABS1, RABSI1: begin
        mem_req = 1'b1;
        aluA = 3'd4; aluB = 3'd6;
        pc = 1'b1; smem = 1'b1;
        if (rdy) nxt = (state == RIMMED) ? tstate : (state == RABS1) ? RABS2 : RABSI2;
      end
      RADDRESS: begin
        mem_req = 1'b1; memAddr = 2'd1; smem = 1'b1;
        if (rdy) nxt = tstate;
      end
      RABS2, RABSI2: begin
        mem_req = 1'b1; memAddr = 2'd2; smem = 1'b1;
        aluA = 3'd5;
        aluB = (state == RABS2) ? 3'd7 : 3'd0;
        if (rdy) nxt = tstate;
      end
      ATYPE: begin
        aluA = src_a; aluB = {1'b0, opcode[4:3]}; aluFunc = opcode[8:5];
        en  = dec(opcode[1:0], opcode[1:0] != 2'd3);
        nxt = take ? IRQ1 : FETCH;
      end
      ITYPE: begin
        aluA = src_a; aluB = 3'd4;
        aluFunc = {opcode[8], opcode[8], opcode[13:12]};
        en  = dec(s1[1:0], !s1[2]);
        nxt = take ? IRQ1 : FETCH;
      end
      JTYPE: begin
        aluA = 3'd4; aluB = 3'd5; aluFunc = 4'b0110; pc = 1'b1;
        nxt = take ? IRQ1 : FETCH;
      end
      IRQ1: begin
        aluA = 3'd4; aluB = 3'd7;
        en  = link_onehot();
        nxt = IRQ2;
      end
      IRQ2: begin
        mem_req = 1'b1; memAddr = 2'd3;
        aluA = 3'd5; aluB = 3'd7;
        pc = 1'b1; ack = 1'b1;
        if (rdy) nxt = FETCH;
      end
      HALT:    nxt = HALT;
      default: nxt = HALT;
    endcase
  end

  // a waiting memory access suppresses every write-back, selects stay put
  assign stall      = mem_req & ~rdy;
  assign enPC       = pc   & ~stall;
  assign saveOpcode = sop  & ~stall;
  assign saveMem    = smem & ~stall;
  assign irq_ack    = ack  & ~stall;
  assign enReg      = stall ? '0 : en;
  assign halted     = (state == HALT);
  assign state_dbg  = state;

endmodule

// File: doc/cpu_controller_irq.md
Name: cpu_controller_irq

Overview:
Parametrised next-generation CPU control FSM for the RCPU datapath. It decodes the 16-bit instruction, sequences the four source addressing modes, and drives ALU, PC and register write controls. Over the single-cycle-memory controller it adds a memory ready handshake (wait states), a configurable register-file width, a vectored interrupt with link save, and an explicit sticky halt status.

Parameters:
NUM_REGS, 3, destination registers; one-hot enReg width (1..4); a decoded index >= NUM_REGS writes nothing
MEM_WAIT, 1, 1: honour mem_ready; 0: mem_ready treated as constant 1
IRQ_EN, 1, 0: irq ignored, IRQ states unreachable
LINK_REG, NUM_REGS-1, register index receiving return PC on interrupt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  16  current instruction (IR bypass, valid in FETCH cycle)
mem_ready  in  1  memory completes the requested access this cycle
irq  in  1  interrupt request, level input, rising-edge detected
memAddr  out  2  address source: 0=PC, 1=A, 2=ALU, 3=IRQ vector
mem_req  out  1  memory access requested this cycle
enPC  out  1  PC write enable
saveOpcode  out  1  IR write enable
saveMem  out  1  internal value register write enable
aluFunc  out  4  ALU function
aluA  out  3  ALU A source: 0-3=reg, 4=PC, 5=MEM
aluB  out  3  ALU B source: 0-3=reg, 4=OP imm, 5=ADDR, 6=const1, 7=const0
enReg  out  NUM_REGS  one-hot register write enable
irq_ack  out  1  one-cycle pulse, interrupt taken
halted  out  1  sticky halt flag
state_dbg  out  5  current state encoding

Behaviour:
- Reset (rst=0, async): state=FETCH, irq pending=0, irq edge register=0. All outputs are then the FETCH decode with halted=0 and irq_ack=0.
- States (5-bit): FETCH=00000, ATYPE=00001, ITYPE=00010, JTYPE=00011, IRQ1=00100, IRQ2=00101, RIMMED=10000, RADDRESS=10001, RABS1=10010, RABS2=10011, RABSI1=10100, RABSI2=10101, HALT=11111.
- Type decode:
  - opcode[15:12]=0000 → ATYPE
  - opcode[15:14]=01 → ITYPE
  - opcode[15]=1 → JTYPE
  - otherwise → HALT
  - s1=opcode[11:9].
- FETCH (mem_req=1, memAddr=0, saveOpcode, PC+1 via aluA=4, aluB=6, aluFunc=0, enPC). On completion:
  - JTYPE, HALT, or s1[2]=0 → type state.
  - s1=100 → RIMMED; 101 → RABS1; 110 → RADDRESS; 111 → RABSI1.
- RIMMED and RABS1/RABSI1: memAddr=0, saveMem, PC+1, mem_req.
- RADDRESS: memAddr=1, saveMem, mem_req.
- RABS2: memAddr=2, saveMem, mem_req, with aluA=5, aluB=7, aluFunc=0.
- RABSI2: as RABS2 but aluB=0 (MEM+A).
- RABS1→RABS2 and RABSI1→RABSI2. Every read-mode final state → type state.
- ATYPE:
  - aluA = s1[2] ? 5 : s1[1:0]; aluB={0,opcode[4:3]}; aluFunc=opcode[8:5].
  - Destination opcode[1:0]; destination 3 = no write.
- ITYPE: aluA as ATYPE; aluB=4; aluFunc={opcode[8],opcode[8],opcode[13:12]}; destination s1[1:0] only when s1[2]=0.
- JTYPE: aluA=4, aluB=5, aluFunc=0110, enPC.
- Execute-state exit: ATYPE, ITYPE and JTYPE are single-cycle, no memory access.
  - Next state is IRQ1 if IRQ_EN and pending=1, else FETCH.
- Interrupts:
  - pending is set on an irq rising edge (irq & ~irq_q).
  - IRQ1: aluA=4, aluB=7, aluFunc=0, enReg[LINK_REG]=1; no memory access; → IRQ2.
  - IRQ2: mem_req, memAddr=3, aluA=5, aluB=7, aluFunc=0, enPC. On completion, irq_ack=1 for that cycle, pending cleared, → FETCH.
  - An edge arriving in the same cycle as the clear re-sets pending (set wins).
- Wait states: in any mem_req state with mem_ready=0 (MEM_WAIT=1):
  - state holds.
  - enPC, saveOpcode, saveMem, enReg and irq_ack are forced 0.
  - Address and ALU selects stay stable.
  - "Completion" means the cycle with mem_ready=1.
- HALT: all enables and mem_req are 0, halted=1, irq ignored, pending frozen; exit only by reset.
- Unused state encodings → HALT.
- Latency, zero wait: register-mode instruction 2 cycles; immediate/address 3; absolute/absolute-indexed 4; interrupt entry adds 2.

Test Plan:
- Reset, opcode=0x0045 (ATYPE, s1=000, dest=01), mem_ready=1 → FETCH: saveOpcode=1, enPC=1. Next cycle ATYPE: aluFunc=0010, enReg=010. Then FETCH.
- Opcode with s1=101 (0x0A00), mem_ready low for 2 cycles during RABS1 → state_dbg holds 10010 for 3 cycles with saveMem=0, enPC=0. Then saveMem=1, enPC=1 → RABS2 (memAddr=2) → ATYPE.
- Opcode 0x1000 → FETCH then HALT, halted=1. Toggling irq and mem_ready → no enables asserted. Asserting rst=0 → FETCH, halted=0.
- irq rising edge during the ITYPE cycle of 0x4200 → IRQ1 with enReg[2]=1, then IRQ2 memAddr=3, enPC=1, irq_ack=1 for one cycle, then FETCH. irq held high afterwards → no second entry.
- IRQ_EN=0 variant: irq pulses every instruction → no IRQ states, irq_ack stays 0.
- NUM_REGS=2: ATYPE with dest=10 → enReg=00; ITYPE with s1=001 → enReg=10.
